// File: rtl/seg7_bin2bcd_pkg.sv
// seg7_bin2bcd_pkg: shared defaults, state encoding and error pattern for the BCD converter.
// Rev 1.0
`default_nettype none

package seg7_bin2bcd_pkg;

   localparam int IN_W_DEF   = 32;
   localparam int DIGITS_DEF = 8;

   // All-ones word; the display driver renders it as a row of F glyphs.
   localparam logic [4*DIGITS_DEF-1:0] BCD_ERR = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic [63:0] pow10(input int n);
      logic [63:0] r;
      r = 64'd1;
      for (int i = 0; i < n; i++) r = r * 64'd10;
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_bin2bcd_add3.sv
// bcd_add3: per-nibble double-dabble correction, adds 3 to any digit of 5 or more.
// Rev 1.0
`default_nettype none

module bcd_add3 (
   input  logic [3:0] din,
   output logic [3:0] dout
);

   assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

`default_nettype wire

// File: rtl/seg7_bin2bcd.sv
// seg7_bin2bcd: sequential double-dabble binary to packed-BCD converter with
// leading-zero mask and overflow flag. Rev 1.0
`default_nettype none

module seg7_bin2bcd
   import seg7_bin2bcd_pkg::*;
#(
   parameter int IN_W   = IN_W_DEF,
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [IN_W-1:0]     in_data,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic [DIGITS-1:0]   lz_mask,
   output logic                ovf,
   output logic                done
);

   localparam int          ACC_W   = 4 * DIGITS;
   localparam int          CNT_W   = $clog2(IN_W);
   localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
   localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};

   state_t            state, state_nx;
   logic [IN_W-1:0]   bin;
   logic [ACC_W-1:0]  acc;
   logic [ACC_W-1:0]  acc_adj;
   logic [ACC_W-1:0]  acc_shift;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_pend;
   logic              accept;
   logic              in_big;
   logic              last;
   logic [DIGITS-1:0] lz_next;
   logic              zero_above;

   assign in_ready  = (state != BUSY);
   assign done      = (state == DONE);
   assign accept    = in_ready & in_valid;
   assign in_big    = 64'(in_data) > MAX_VAL;
   assign last      = (cnt == CNT_W'(IN_W - 1));
   assign acc_shift = {acc_adj[ACC_W-2:0], bin[IN_W-1]};

   for (genvar i = 0; i < DIGITS; i++) begin : g_add3
      bcd_add3 u_add3 (
         .din  (acc[4*i +: 4]),
         .dout (acc_adj[4*i +: 4])
      );
   end

   always_comb begin
      lz_next    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (acc_shift[4*i +: 4] == 4'd0);
         lz_next[i] = zero_above;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Out-of-range inputs still spend one BUSY cycle so they report after the
   // edge following acceptance, like a one-bit conversion would.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE, DONE: state_nx = accept ? BUSY : IDLE;
         BUSY:       state_nx = (ovf_pend || last) ? DONE : BUSY;
         default:    state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bin      <= '0;
         acc      <= '0;
         cnt      <= '0;
         ovf_pend <= 1'b0;
         bcd_out  <= '0;
         lz_mask  <= LZ_RST;
         ovf      <= 1'b0;
      end else if (accept) begin
         bin      <= in_big ? '0 : in_data;
         acc      <= '0;
         cnt      <= '0;
         ovf_pend <= in_big;
      end else if (state == BUSY) begin
         if (ovf_pend) begin
            ovf_pend <= 1'b0;
            bcd_out  <= {DIGITS{BCD_ERR[3:0]}};
            lz_mask  <= '0;
            ovf      <= 1'b1;
         end else begin
            acc <= acc_shift;
            bin <= {bin[IN_W-2:0], 1'b0};
            cnt <= cnt + 1'b1;
            if (last) begin
               bcd_out <= acc_shift;
               lz_mask <= lz_next;
               ovf     <= 1'b0;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seg7_bin2bcd.sv
// tb_seg7_bin2bcd: directed scoreboard bench for seg7_bin2bcd. Rev 1.0
`default_nettype none

module tb_seg7_bin2bcd;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [31:0] bcd_out;
   logic [7:0]  lz_mask;
   logic        ovf;
   logic        done;

   typedef struct {
      logic [31:0] bcd;
      logic [7:0]  lz;
      logic        ov;
      time         t_done;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   seg7_bin2bcd #(.IN_W(32), .DIGITS(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .bcd_out  (bcd_out),
      .lz_mask  (lz_mask),
      .ovf      (ovf),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && done) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: actual bcd=%0h required no result", bcd_out);
         end else begin
            e = q.pop_front();
            chk("bcd_out", bcd_out, e.bcd);
            chk("lz_mask", {24'd0, lz_mask}, {24'd0, e.lz});
            chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
            chk("done_time", 32'($time), 32'(e.t_done));
            chk("ready_in_done", {31'd0, in_ready}, 32'd1);
         end
      end
   end

   // Results appear after edge N+lat; sampled on the following falling edge.
   task automatic issue(input logic [31:0] v, input logic [31:0] eb, input logic [7:0] el,
                        input logic eo, input int lat);
      int n;
      exp_t e;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      in_data  = v;
      @(posedge clk);
      e.bcd = eb; e.lz = el; e.ov = eo; e.t_done = $time + lat * 10 + 5;
      q.push_back(e);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", 32'(q.size()), 32'd0);
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
      chk({tag, "_bcd"}, bcd_out, 32'd0);
      chk({tag, "_lz"}, {24'd0, lz_mask}, 32'h0000_00FE);
      chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
      chk({tag, "_done"}, {31'd0, done}, 32'd0);
   endtask

   initial begin
      exp_t e;
      int   n;
      #22;
      chk_reset_state("rst");
      @(negedge clk);
      rst_n = 1'b1;

      issue(32'd12345678, 32'h1234_5678, 8'h00, 1'b0, 32);
      @(negedge clk);
      chk("busy_ready", {31'd0, in_ready}, 32'd0);
      drain();

      issue(32'd0,   32'h0000_0000, 8'hFE, 1'b0, 32);
      drain();
      issue(32'd905, 32'h0000_0905, 8'hF8, 1'b0, 32);
      drain();
      issue(32'd99999999, 32'h9999_9999, 8'h00, 1'b0, 32);
      drain();

      // Back-to-back: in_valid stays high with changing data while BUSY.
      issue(32'd1234, 32'h0000_1234, 8'hF0, 1'b0, 32);
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!done && n < 60) begin
         in_data = $urandom_range(32'd1, 32'd99999999);
         @(negedge clk);
         n++;
      end
      if (!done) chk("b2b_timeout", {31'd0, done}, 32'd1);
      in_data = 32'd5678;
      @(posedge clk);
      e.bcd = 32'h0000_5678; e.lz = 8'hF0; e.ov = 1'b0; e.t_done = $time + 32 * 10 + 5;
      q.push_back(e);
      #1 in_valid = 1'b0;
      drain();

      issue(32'd100000000, 32'hFFFF_FFFF, 8'h00, 1'b1, 1);
      drain();
      issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'h00, 1'b1, 1);
      drain();

      // Reset mid-conversion (cnt==15), between clock edges.
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 32'd87654321;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (15) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_state("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      issue(32'd42, 32'h0000_0042, 8'hFC, 1'b0, 32);
      drain();
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
